async_queue_rd: RTL
===================

# async_queue_rd

Read-side stream adapter sitting directly downstream of the read port of the dual-clock queue, in the read clock domain. Converts the queue's empty/pop/combinational-data interface into a registered valid/ready stream. Uses a registered pop and a 2-entry output buffer, so there is no combinational path from the consumer's ready back to the queue's pop, and throughput is one word per cycle.

## Interface
- W, 32, data word width; must equal the queue's W.
- clk  input  1  read-domain clock; the same clock as the queue's rclk.
- rst_n  input  1  synchronous, active-low reset.
- q_empty  input  1  queue empty flag; reflects occupancy after any pop issued in the same cycle.
- q_pop  output  1  pop strobe to the queue; driven directly from a flop.
- q_data  input  W  queue head word; valid in any cycle where q_pop is high.
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  W  output word; driven from a flop.
- perf_pop_cnt  output  16  number of words popped (present only with ASYNC_QUEUE_RD_PERF_EN).
- perf_stall_cnt  output  16  cycles with out_valid high and out_ready low (present only with ASYNC_QUEUE_RD_PERF_EN).

## Operation
- Buffer: 2 entries, buf0 (head, drives out_data) and buf1 (skid).
  - count_r ∈ {0,1,2}.
  - out_valid = (count_r != 0).
- Capture: when q_pop = 1, q_data is written at the clock edge that ends that cycle.
  - Into buf0 if the post-drain count is 0, otherwise into buf1.
- Drain (out_valid & out_ready): buf1 moves to buf0 and count decrements.
  - A drain and a capture in the same cycle leave count unchanged; the new word goes to the tail.
- Occupancy arithmetic per cycle: count_nxt = count_r + q_pop − (out_valid & out_ready).
- Pop decision: q_pop_nxt = !q_empty & (count_nxt + 1 ≤ 2), registered into q_pop.
  - q_empty is sampled in the same cycle, with the current q_pop already applied by the queue.
  - Entries never vanish from a non-empty queue; only the writer advances the synchronized pointer. So q_pop is never high while the queue is empty.
- Invariant: count_r + q_pop ≤ 2 in every cycle.
  - A capture can never find the buffer full.
  - The bench asserts this invariant.
- Ordering is strict FIFO; no word is dropped or duplicated.
- There is no FSM beyond count_r. Functional states are:
  - EMPTY (count 0)
  - ONE (count 1)
  - FULL (count 2)
- Transitions follow count_nxt.

## Timing
- Reset values while rst_n is low at a clock edge:
  - q_pop = 0
  - count_r = 0
  - out_valid = 0
  - out_data = 0
  - perf counters = 0
- The queue's rrst must be asserted for at least the same cycles.
- Reset mid-operation: buffered words and any in-flight pop are discarded.
  - The first q_pop is possible in the first cycle after rst_n rises, if !q_empty was seen in that cycle.
- Latency from q_empty falling (cycle t) to output:
  - q_pop = 1 in cycle t+1.
  - out_valid = 1 in cycle t+2, with that word on out_data.
- Steady state with out_ready held high: one word per cycle on both q_pop and the output; count_r stays at 1.
- Back-pressure: out_ready low stops pops after at most one in-flight pop.
  - count_r reaches 2.
  - q_pop stays 0 until a drain makes room.
- out_data and out_valid are stable while out_valid & !out_ready.
- out_ready may toggle freely; out_valid never depends combinationally on out_ready.

## Configuration
- ASYNC_QUEUE_RD_PERF_EN defined:
  - perf_pop_cnt increments on every cycle with q_pop = 1.
  - perf_stall_cnt increments on every cycle with out_valid & !out_ready.
  - Both are 16 bits, saturate at 16'hFFFF, and clear only on reset.
- Not defined: both ports and all counter logic are absent.
- Datapath behaviour is identical either way.

## Test plan
- Reset hold: rst_n low for 3 cycles with q_empty = 0 → q_pop = 0 and out_valid = 0 throughout; first q_pop appears in the cycle after rst_n rises.
- Single word: q_empty falls at cycle 10 with head word 32'hA5A5_0001 → q_pop high in cycle 11 only; out_valid high in cycle 12 with out_data = 32'hA5A5_0001.
- Streaming: 64 queued words 0..63 with out_ready = 1 → 64 consecutive pop cycles; output beats 0..63 back-to-back; count_r never exceeds 1 after the first beat.
- Back-pressure: out_ready low for 20 cycles during a stream of 10 words →
  - count_r = 2 and q_pop = 0 for the remainder of the stall;
  - output order preserved;
  - perf_stall_cnt = 20 (PERF_EN).
- Random ready: 1000 words with random q_empty gaps and 50% random out_ready → scoreboard matches exactly; invariant count_r + q_pop ≤ 2 holds; perf_pop_cnt = 1000.
- Mid-stream reset: rst_n low for 1 cycle while count_r = 2 and q_pop = 1 → out_valid = 0 in the next cycle, no stale word emitted, and perf counters = 0.

Source files
------------

// File: rtl/async_queue_rd.sv
// async_queue_rd: read-side adapter turning the dual-clock queue's empty/pop/data port into a registered valid/ready stream.
// Latency: q_empty falling in cycle t gives q_pop in t+1 and out_valid with that word in t+2; one word per cycle sustained.
// Backpressure: a 2-entry buffer absorbs the one in-flight pop, so out_ready never reaches q_pop combinationally.
//
// Ports: clk (read-domain clock, same as the queue's rclk), rst_n (synchronous, active-low),
//        q_empty / q_pop / q_data (queue read port), out_valid / out_ready / out_data (output stream),
//        perf_pop_cnt / perf_stall_cnt (saturating 16-bit counters, present only with ASYNC_QUEUE_RD_PERF_EN).
// Optional feature macro: ASYNC_QUEUE_RD_PERF_EN.
module async_queue_rd #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         q_empty,
  output logic         q_pop,
  input  logic [W-1:0] q_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef ASYNC_QUEUE_RD_PERF_EN
  ,
  output logic [15:0]  perf_pop_cnt,
  output logic [15:0]  perf_stall_cnt
`endif
);

  // Functional states are just the buffer occupancy.
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;

  logic [1:0]   count_r;
  logic [1:0]   count_nxt;
  logic [1:0]   post_drain_cnt;
  logic         drain;
  logic         q_pop_nxt;
  logic [W-1:0] buf0;
  logic [W-1:0] buf1;

  assign out_valid = (count_r != CNT_EMPTY);
  assign out_data  = buf0;
  assign drain     = out_valid & out_ready;

  // count_r + q_pop never exceeds 2, so neither expression can wrap.
  assign post_drain_cnt = count_r - {1'b0, drain};
  assign count_nxt      = post_drain_cnt + {1'b0, q_pop};

  // Only request a word if there will still be a free slot for it next
  // cycle, counting the pop that is already in flight.
  assign q_pop_nxt = !q_empty && (count_nxt <= CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_pop   <= 1'b0;
      count_r <= CNT_EMPTY;
      buf0    <= '0;
    end else begin
      q_pop   <= q_pop_nxt;
      count_r <= count_nxt;
      if (drain) begin
        buf0 <= buf1;
      end
      // A captured word lands in the head slot when the buffer is empty
      // after this cycle's drain; the later assignment overrides the shift.
      if (q_pop) begin
        if (post_drain_cnt == CNT_EMPTY) begin
          buf0 <= q_data;
        end else begin
          buf1 <= q_data;
        end
      end
    end
  end

`ifdef ASYNC_QUEUE_RD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_pop_cnt   <= 16'h0000;
      perf_stall_cnt <= 16'h0000;
    end else begin
      if (q_pop && (perf_pop_cnt != 16'hFFFF)) begin
        perf_pop_cnt <= perf_pop_cnt + 16'h0001;
      end
      if (out_valid && !out_ready && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule
